// File: rtl/counter_request_arbiter.sv
// Grants up/down/load requests (four-phase req/ack) one at a time to a shared
// counter and pushes every resulting value into the downstream FIFO before acking.
module counter_request_arbiter #(
   parameter int WIDTH          = 4,
   parameter bit ROUND_ROBIN    = 1'b0,
   parameter bit DROP_WHEN_FULL = 1'b0
) (
   input  logic             systemClock,
   input  logic             resetButton,
   input  logic             upReq,
   output logic             upAck,
   input  logic             downReq,
   output logic             downAck,
   input  logic             loadReq,
   output logic             loadAck,
   input  logic [WIDTH-1:0] switches,
   output logic [WIDTH-1:0] counter,
   output logic             fifoWrite,
   output logic [WIDTH-1:0] fifoData,
   input  logic             fifoFull,
   output logic             busy,
   output logic [7:0]       droppedCount
);

   typedef enum logic [2:0] {IDLE, EXEC, PUSH, ACK, RELEASE} state_t;
   typedef enum logic [1:0] {SEL_UP, SEL_DOWN, SEL_LOAD} sel_t;

   state_t     state;
   sel_t       sel;
   sel_t       winner;
   logic       rrLastUp;
   logic       ackOn;
   logic       selReq;
   logic [2:0] reqVec;
   logic [2:0] armed;
   logic [2:0] eligible;

   // Bit order {load, down, up}; a requester only counts once it has been seen low.
   assign reqVec   = {loadReq, downReq, upReq};
   assign eligible = armed & reqVec;

   always_comb begin
      winner = SEL_UP;
      if (eligible[2])
         winner = SEL_LOAD;
      else if (eligible[0] && eligible[1])
         winner = (ROUND_ROBIN && rrLastUp) ? SEL_DOWN : SEL_UP;
      else if (eligible[0])
         winner = SEL_UP;
      else if (eligible[1])
         winner = SEL_DOWN;
   end

   always_comb begin
      selReq = 1'b0;
      case (sel)
         SEL_UP:   selReq = upReq;
         SEL_DOWN: selReq = downReq;
         SEL_LOAD: selReq = loadReq;
         default:  selReq = 1'b0;
      endcase
   end

   always_ff @(posedge systemClock) begin
      if (resetButton) begin
         state        <= IDLE;
         sel          <= SEL_UP;
         rrLastUp     <= 1'b0;
         ackOn        <= 1'b0;
         armed        <= 3'b000;
         counter      <= '0;
         fifoWrite    <= 1'b0;
         fifoData     <= '0;
         droppedCount <= 8'd0;
      end else begin
         armed     <= armed | ~reqVec;
         fifoWrite <= 1'b0;
         case (state)
            IDLE: begin
               if (|eligible) begin
                  sel   <= winner;
                  state <= EXEC;
                  if (winner != SEL_LOAD)
                     rrLastUp <= (winner == SEL_UP);
               end
            end
            EXEC: begin
               case (sel)
                  SEL_UP:   counter <= counter + WIDTH'(1);
                  SEL_DOWN: counter <= counter - WIDTH'(1);
                  default:  counter <= switches;
               endcase
               state <= PUSH;
            end
            PUSH: begin
               if (!fifoFull) begin
                  fifoWrite <= 1'b1;
                  fifoData  <= counter;
                  state     <= ACK;
               end else if (DROP_WHEN_FULL) begin
                  if (droppedCount != 8'hFF)
                     droppedCount <= droppedCount + 8'd1;
                  state <= ACK;
               end
            end
            // Ack rises one cycle after entering ACK so it trails the write strobe.
            ACK: begin
               if (!ackOn)
                  ackOn <= 1'b1;
               else if (!selReq) begin
                  ackOn <= 1'b0;
                  state <= RELEASE;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign upAck   = ackOn && (sel == SEL_UP);
   assign downAck = ackOn && (sel == SEL_DOWN);
   assign loadAck = ackOn && (sel == SEL_LOAD);
   assign busy    = (state != IDLE);

endmodule

// File: doc/counter_request_arbiter.md
Name: counter_request_arbiter

Overview:
- Sequences the shared WIDTH-bit up/down/load counter for the counter-with-FIFO project.
- Accepts debounced up, down and load requests over independent four-phase req/ack handshakes.
- Grants one request at a time and applies it to the counter.
- Pushes each resulting counter value into the downstream FIFO write port before acknowledging the requester.

Parameters:
- WIDTH, 4, counter and switch width.
- ROUND_ROBIN, 0: 0 = fixed priority load > up > down; 1 = load highest, up/down alternate.
- DROP_WHEN_FULL, 0: 0 = stall in PUSH while fifoFull; 1 = skip the write and count a drop.

Ports:
- systemClock  in  1  system clock; all state changes on its rising edge.
- resetButton  in  1  reset, synchronous, active-high.
- upReq  in  1  increment request (four-phase).
- upAck  out  1  increment acknowledge.
- downReq  in  1  decrement request.
- downAck  out  1  decrement acknowledge.
- loadReq  in  1  load request.
- loadAck  out  1  load acknowledge.
- switches  in  WIDTH  load value, sampled in EXEC.
- counter  out  WIDTH  current counter value (registered).
- fifoWrite  out  1  single-cycle FIFO write strobe.
- fifoData  out  WIDTH  FIFO write data; valid when fifoWrite=1.
- fifoFull  in  1  FIFO full flag.
- busy  out  1  high whenever state != IDLE.
- droppedCount  out  8  saturating count of skipped writes (DROP_WHEN_FULL=1 only; else 0).

Behaviour:
- Reset (resetButton high at an edge):
  - Outputs: counter=0, all acks=0, fifoWrite=0, fifoData=0, busy=0, droppedCount=0, state=IDLE.
  - Internal: rrLast=down, so up wins the first tie.
  - Clears the per-requester armed flags.
  - Reset mid-operation aborts immediately; no write is issued and any asserted ack drops at that edge.
- Arming: a requester is armed after its req is sampled low at least once since reset. Only armed requests are eligible. A req held high through reset is ignored until it returns low.
- FSM states: IDLE, EXEC, PUSH, ACK, RELEASE.
- IDLE: if any eligible req is high, latch the winner and go to EXEC; otherwise stay.
  - ROUND_ROBIN=0: priority is load > up > down.
  - ROUND_ROBIN=1: load wins; an up/down tie goes opposite to rrLast, and rrLast is updated on each up/down grant.
- EXEC (one cycle): counter updates at the end of this cycle, then go to PUSH.
  - up: counter+1 mod 2^WIDTH; 15 -> 0.
  - down: counter-1 mod 2^WIDTH; 0 -> 15.
  - load: counter <= switches.
- PUSH:
  - fifoFull=0: fifoWrite=1 and fifoData=counter for exactly one cycle, then ACK.
  - fifoFull=1 and DROP_WHEN_FULL=0: wait with fifoWrite=0; counter is held.
  - fifoFull=1 and DROP_WHEN_FULL=1: no write; droppedCount+1, saturating at 255; go to ACK.
- ACK: the winner's ack is high and stays high until its req is sampled low, then go to RELEASE.
- RELEASE: ack is deasserted (low from this cycle), then go to IDLE. A new grant is possible in the following cycle.
- Only the granted ack is ever high; no two acks are high simultaneously.
- Latency: req sampled high at edge N gives counter updated at N+1, fifoWrite high in cycle N+2 if not full, and ack high from N+3.
- Simultaneous events:
  - Requests arriving while busy stay pending until IDLE and are not lost, provided the requester holds req.
  - A req that drops before being granted is withdrawn; no action is taken.
- busy=1 in all states except IDLE.

Test Plan:
- Reset, then pulse upReq with the four-phase protocol -> counter 0 -> 1; one fifoWrite with fifoData=1; upAck high until upReq low, then low one cycle later.
- Preset counter=15, then up -> counter 0 and fifoData=0. Preset counter=0, then down -> counter 15 and fifoData=15.
- switches=11, loadReq and upReq raised on the same edge (ROUND_ROBIN=0) -> load served first (counter=11, write 11); after loadReq releases, up is served (counter=12, write 12).
- ROUND_ROBIN=1 with upReq and downReq both held and reasserted repeatedly from counter=5 -> grants alternate up, down, up; counter sequence 6, 5, 6.
- fifoFull=1 during an up with DROP_WHEN_FULL=0 -> stays in PUSH, busy=1, no ack; after fifoFull goes low, exactly one write and then ack. With DROP_WHEN_FULL=1 -> no write, droppedCount=1, ack still issued.
- Reset asserted during PUSH with upReq held high -> counter=0, ack low, no write. upReq stays unserviced until it drops and re-rises; the re-rise gives counter=1.
